// File: rtl/blink_pkg.sv
// Shared types and helpers for the multi-channel blinker.
// Build option BLINK_SAT_EN selects saturating accumulation (see blink_multi).
package blink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACC    = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blink_acc_unit.sv
// Shared accumulator adder; wraps by default, saturates when BLINK_SAT_EN is defined.
module blink_acc_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic [CNT_W-1:0] i_operand,
    input  logic [CNT_W-1:0] i_incr,
    output logic [CNT_W-1:0] o_next_c
`ifdef BLINK_SAT_EN
    ,
    output logic             o_ovf_c
`endif
);

`ifdef BLINK_SAT_EN
    logic [CNT_W:0] w_full;

    assign w_full   = {1'b0, i_operand} + {1'b0, i_incr};
    assign o_ovf_c  = w_full[CNT_W];
    assign o_next_c = o_ovf_c ? '1 : w_full[CNT_W-1:0];
`else
    assign o_next_c = i_operand + i_incr;
`endif

endmodule

// File: rtl/blink_multi.sv
// Multi-channel LED blinker: per-channel accumulators advanced round-robin through one adder.
// Build option BLINK_SAT_EN: saturating adds plus sticky per-channel sat flags.
module blink_multi
    import blink_pkg::*;
#(
    parameter int unsigned     NUM_CH     = 4,
    parameter int unsigned     CNT_W      = 32,
    parameter int unsigned     LED_W      = 8,
    parameter int unsigned     LED_LSB    = 16,
    parameter int unsigned     SETTLE_CYC = 1,
    parameter logic [CNT_W-1:0] INCR_RST  = CNT_W'(1)
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NUM_CH-1:0]           enable,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [idx_w(NUM_CH)-1:0]    wr_ch,
    input  logic [CNT_W-1:0]            wr_data,
    output logic [NUM_CH*LED_W-1:0]     led,
    output logic                        busy,
    output logic                        done
`ifdef BLINK_SAT_EN
    ,
    output logic [NUM_CH-1:0]           sat
`endif
);

    localparam int unsigned CH_W  = idx_w(NUM_CH);
    localparam int unsigned SET_W = idx_w(SETTLE_CYC);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

    state_t             r_state,    w_state_nxt;
    logic [CH_W-1:0]    r_ch_idx,   w_ch_idx_nxt;
    logic [SET_W-1:0]   r_settle,   w_settle_nxt;
    logic [NUM_CH-1:0]  r_mask,     w_mask_nxt;
    logic               r_busy;
    logic               r_done,     w_done_nxt;
    logic               w_acc_fire;

    logic [CNT_W-1:0]   r_count [NUM_CH];
    logic [CNT_W-1:0]   r_incr  [NUM_CH];
    logic [CNT_W-1:0]   w_operand;
    logic [CNT_W-1:0]   w_incr_sel;
    logic [CNT_W-1:0]   w_sum;

    // Next-state logic; clr aborts any pass without a done pulse
    always_comb begin
        w_state_nxt  = r_state;
        w_ch_idx_nxt = r_ch_idx;
        w_settle_nxt = r_settle;
        w_mask_nxt   = r_mask;
        w_done_nxt   = 1'b0;
        w_acc_fire   = 1'b0;
        if (clr) begin
            w_state_nxt  = ST_IDLE;
            w_ch_idx_nxt = '0;
            w_settle_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|enable) begin
                        w_mask_nxt   = enable;
                        w_settle_nxt = SETTLE_LOAD;
                        w_state_nxt  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        w_state_nxt  = ST_ACC;
                        w_ch_idx_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle - SET_W'(1);
                    end
                end
                ST_ACC: begin
                    w_acc_fire = r_mask[r_ch_idx];
                    if (r_ch_idx == LAST_CH) begin
                        w_state_nxt  = ST_IDLE;
                        w_ch_idx_nxt = '0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_ch_idx_nxt = r_ch_idx + CH_W'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_ch_idx <= '0;
            r_settle <= '0;
            r_mask   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ch_idx <= w_ch_idx_nxt;
            r_settle <= w_settle_nxt;
            r_mask   <= w_mask_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign w_operand  = r_count[r_ch_idx];
    assign w_incr_sel = r_incr[r_ch_idx];

`ifdef BLINK_SAT_EN
    logic               w_ovf;
    logic [NUM_CH-1:0]  r_sat;

    blink_acc_unit #(.CNT_W(CNT_W)) u_acc (
        .i_operand (w_operand),
        .i_incr    (w_incr_sel),
        .o_next_c  (w_sum),
        .o_ovf_c   (w_ovf)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sat <= '0;
        end else if (clr) begin
            r_sat <= '0;
        end else if (w_acc_fire && w_ovf) begin
            r_sat[r_ch_idx] <= 1'b1;
        end
    end

    assign sat = r_sat;
`else
    blink_acc_unit #(.CNT_W(CNT_W)) u_acc (
        .i_operand (w_operand),
        .i_incr    (w_incr_sel),
        .o_next_c  (w_sum)
    );
`endif

    // Increment writes land on the edge, so a same-cycle ACC still adds the old value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NUM_CH); i++) r_incr[i] <= INCR_RST;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (wr_en && (wr_ch == CH_W'(i))) r_incr[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NUM_CH); i++) r_count[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < int'(NUM_CH); i++) r_count[i] <= '0;
        end else if (w_acc_fire) begin
            r_count[r_ch_idx] <= w_sum;
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_led
        assign led[g*LED_W +: LED_W] = r_count[g][LED_LSB +: LED_W];
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_blink_multi.sv
// Self-checking bench for blink_multi against a pass-level accumulator model.
module tb_blink_multi;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned LED_LSB = 16;

    logic                   CLK = 1'b0;
    logic                   RST_N = 1'b0;
    logic [NUM_CH-1:0]      enable = '0;
    logic                   clr = 1'b0;
    logic                   wr_en = 1'b0;
    logic [1:0]             wr_ch = '0;
    logic [CNT_W-1:0]       wr_data = '0;
    logic [NUM_CH*LED_W-1:0] led;
    logic                   busy;
    logic                   done;
`ifdef BLINK_SAT_EN
    logic [NUM_CH-1:0]      sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [CNT_W-1:0] m_count [NUM_CH];
    logic [CNT_W-1:0] m_incr  [NUM_CH];
    logic [NUM_CH-1:0] m_sat;

    always #5 CLK = ~CLK;

    blink_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LED_W(LED_W), .LED_LSB(LED_LSB),
        .SETTLE_CYC(1), .INCR_RST(32'd1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable), .clr(clr),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .led(led), .busy(busy), .done(done)
`ifdef BLINK_SAT_EN
        , .sat(sat)
`endif
    );

    function automatic logic [CNT_W-1:0] m_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef BLINK_SAT_EN
        if (s[CNT_W]) return '1;
`endif
        return s[CNT_W-1:0];
    endfunction

    function automatic logic m_ovf(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W];
    endfunction

    function automatic logic [NUM_CH*LED_W-1:0] exp_led();
        logic [NUM_CH*LED_W-1:0] e;
        for (int i = 0; i < int'(NUM_CH); i++) e[i*LED_W +: LED_W] = m_count[i][LED_LSB +: LED_W];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_count[i] = '0;
            m_incr[i]  = 32'd1;
        end
        m_sat = '0;
    endtask

    task automatic model_pass(input logic [NUM_CH-1:0] mask);
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (mask[i]) begin
                if (m_ovf(m_count[i], m_incr[i])) m_sat[i] = 1'b1;
                m_count[i] = m_add(m_count[i], m_incr[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_incr(input int ch, input logic [CNT_W-1:0] val);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_data = val;
        tick();
        wr_en = 1'b0;
        m_incr[ch] = val;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) m_count[i] = '0;
        m_sat = '0;
    endtask

    // Start a pass with mask, optionally toggling enable randomly mid-pass, and wait for done
    task automatic run_pass(input logic [NUM_CH-1:0] mask, input bit noisy, output bit ok);
        ok = 1'b0;
        enable = mask;
        tick();
        enable = '0;
        for (int c = 0; c < 40; c++) begin
            if (noisy) enable = 4'($urandom);
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        enable = '0;
        model_pass(mask);
    endtask

    task automatic test_reset();
        int seen_busy, seen_done;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (led !== '0)  begin n_fail++; $display("FAIL reset_led: got %h expected 0", led); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        RST_N = 1'b1;
        model_reset();
        seen_busy = 0; seen_done = 0;
        repeat (20) begin
            tick();
            if (busy) seen_busy++;
            if (done) seen_done++;
        end
        n_checks++; if (led !== '0) begin n_fail++; $display("FAIL idle_led: got %h expected 0", led); end
        n_checks++; if (seen_busy != 0) begin n_fail++; $display("FAIL idle_busy: got %0d busy cycles expected 0", seen_busy); end
        n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL idle_done: got %0d pulses expected 0", seen_done); end
    endtask

    task automatic test_single();
        int busy_cyc, done_cyc, led_at, done_at;
        pulse_clr();
        write_incr(2, 32'h0001_0000);
        enable = 4'b0100;
        tick();
        enable = '0;
        busy_cyc = 0; done_cyc = 0; led_at = -1; done_at = -1;
        for (int c = 1; c <= 12; c++) begin
            if (busy) busy_cyc++;
            if (done) begin done_cyc++; done_at = c; end
            if (led[23:16] != 8'h00 && led_at < 0) led_at = c;
            tick();
        end
        model_pass(4'b0100);
        n_checks++; if (busy_cyc != 1 + int'(NUM_CH)) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", busy_cyc, 1 + NUM_CH); end
        n_checks++; if (done_cyc != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d expected 1", done_cyc); end
        n_checks++; if (led_at != 5) begin n_fail++; $display("FAIL single_ch2_timing: got cycle %0d expected 5", led_at); end
        n_checks++; if (done_at != 6) begin n_fail++; $display("FAIL single_done_timing: got cycle %0d expected 6", done_at); end
        n_checks++; if (led !== 32'h0001_0000) begin n_fail++; $display("FAIL single_led: got %h expected 00010000", led); end
        n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL single_led_model: got %h expected %h", led, exp_led()); end
    endtask

    task automatic test_all_repeat();
        int n, extra;
        pulse_clr();
        for (int i = 0; i < int'(NUM_CH); i++) write_incr(i, 32'((i + 1) << 16));
        enable = 4'hF;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (done) begin
                n++;
                if (n == 10) begin
                    enable = '0;
                    break;
                end
            end
        end
        enable = '0;
        repeat (10) model_pass(4'hF);
        extra = 0;
        repeat (10) begin
            tick();
            if (done || busy) extra++;
        end
        n_checks++; if (n != 10) begin n_fail++; $display("FAIL repeat_done_cnt: got %0d expected 10", n); end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL repeat_extra_pass: got %0d active cycles expected 0", extra); end
        n_checks++; if (led !== 32'h281E_140A) begin n_fail++; $display("FAIL repeat_led: got %h expected 281e140a", led); end
        n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL repeat_led_model: got %h expected %h", led, exp_led()); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [LED_W-1:0] want;
        pulse_clr();
        write_incr(0, 32'hFFFF_0000);
        for (int p = 0; p < 2; p++) begin
            run_pass(4'b0001, 1'b0, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_pass%0d_timeout: got no done expected done", p); end
        end
`ifdef BLINK_SAT_EN
        want = 8'hFF;
        n_checks++; if (sat !== 4'b0001) begin n_fail++; $display("FAIL wrap_sat: got %b expected 0001", sat); end
        n_checks++; if (sat !== m_sat) begin n_fail++; $display("FAIL wrap_sat_model: got %b expected %b", sat, m_sat); end
`else
        want = 8'hFE;
`endif
        n_checks++; if (led[7:0] !== want) begin n_fail++; $display("FAIL wrap_ch0: got %h expected %h", led[7:0], want); end
        n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL wrap_led_model: got %h expected %h", led, exp_led()); end
    endtask

    task automatic test_collision();
        bit ok;
        pulse_clr();
        write_incr(1, 32'h0001_0000);
        enable = 4'b0010;
        tick();
        enable = '0;
        tick();
        enable = 4'hF;
        tick();
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 32'h0002_0000;
        tick();
        wr_en = 1'b0;
        enable = '0;
        n_checks++; if (led[15:8] !== 8'h01) begin n_fail++; $display("FAIL collide_old_incr: got %h expected 01", led[15:8]); end
        model_pass(4'b0010);
        m_incr[1] = 32'h0002_0000;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL collide_done_timeout: got no done expected done"); end
        n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL collide_mask_frozen: got %h expected %h", led, exp_led()); end
        run_pass(4'b0010, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL collide_pass2_timeout: got no done expected done"); end
        n_checks++; if (led[15:8] !== 8'h03) begin n_fail++; $display("FAIL collide_new_incr: got %h expected 03", led[15:8]); end
    endtask

    task automatic test_random();
        bit ok;
        logic [NUM_CH-1:0] mask;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 7) == 0) pulse_clr();
            repeat (2) write_incr(int'($urandom_range(0, NUM_CH - 1)), $urandom);
            mask = 4'($urandom_range(1, 15));
            run_pass(mask, 1'b1, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL random_%0d_timeout: got no done expected done", it); end
            n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL random_%0d_led: mask %b got %h expected %h", it, mask, led, exp_led()); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int active;
        pulse_clr();
        for (int i = 0; i < int'(NUM_CH); i++) write_incr(i, 32'((i + 1) << 16));
        run_pass(4'hF, 1'b0, ok);
        n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL abort_pre_led: got %h expected %h", led, exp_led()); end
        enable = 4'hF;
        tick();
        enable = '0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) m_count[i] = '0;
        n_checks++; if (led !== '0) begin n_fail++; $display("FAIL abort_clr_led: got %h expected 0", led); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_clr_busy: got %b expected 0", busy); end
        active = 0;
        repeat (12) begin
            tick();
            if (done || busy) active++;
        end
        n_checks++; if (active != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", active); end

        // Async reset in SETTLE must clear outputs before any further edge
        run_pass(4'hF, 1'b0, ok);
        n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL arst_pre_led: got %h expected %h", led, exp_led()); end
        enable = 4'hF;
        tick();
        enable = '0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_settle_busy: got %b expected 1", busy); end
        #2 RST_N = 1'b0;
        #1;
        n_checks++; if (led !== '0) begin n_fail++; $display("FAIL arst_led: got %h expected 0", led); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
        #2 RST_N = 1'b1;
        model_reset();
        active = 0;
        repeat (10) begin
            tick();
            if (done || busy) active++;
        end
        n_checks++; if (active != 0) begin n_fail++; $display("FAIL arst_no_done: got %0d active cycles expected 0", active); end
        run_pass(4'hF, 1'b0, ok);
        n_checks++; if (led !== exp_led()) begin n_fail++; $display("FAIL arst_incr_reset: got %h expected %h", led, exp_led()); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_repeat();
        test_wrap();
        test_collision();
        test_random();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_multi.md
Name: blink_multi

Overview:
Multi-channel, parametrised successor of the single-channel LED blinker.
- Each of NUM_CH channels holds a CNT_W-bit accumulator.
- Each accumulator advances by a per-channel programmable increment, through one shared adder serviced round-robin by a small FSM.
- Each channel drives an LED_W-bit window of its accumulator.
- Sits between the control/register interface (increment writes, enable, clear) and board LED pins or a status bus.

Parameters:
NUM_CH, 4, number of channels (1..16)
CNT_W, 32, accumulator and increment width
LED_W, 8, LED window width per channel
LED_LSB, 16, accumulator bit index of the LED window LSB; LED_LSB+LED_W <= CNT_W
SETTLE_CYC, 1, cycles spent in SETTLE before accumulation (>=1)
INCR_RST, 1, reset value of every increment register

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous assert, active-low
enable  in  NUM_CH  per-channel request mask; sampled in IDLE
clr  in  1  synchronous clear of all accumulators
wr_en  in  1  increment register write strobe
wr_ch  in  $clog2(NUM_CH) (min 1)  channel addressed by the write
wr_data  in  CNT_W  increment value
led  out  NUM_CH*LED_W  channel i = count[i][LED_LSB+LED_W-1:LED_LSB] at led[i*LED_W +: LED_W]
busy  out  1  high in SETTLE and ACC
done  out  1  one-cycle pulse after the last ACC cycle

Behaviour:
- Reset (RST_N low, asynchronous):
  - count[*]=0; incr[*]=INCR_RST; state=IDLE; mask=0; ch_idx=0; settle counter=0.
  - led=0, busy=0, done=0.
- Registers:
  - led is combinational from count, so 0-cycle latency after a count update.
  - done and busy are registered from the state.
- FSM states: IDLE, SETTLE, ACC.
  - IDLE: if |enable, latch mask<=enable, load settle counter, go to SETTLE. Otherwise stay.
  - SETTLE: count down SETTLE_CYC cycles, then go to ACC with ch_idx=0.
  - ACC: one channel per cycle. If mask[ch_idx], count[ch_idx] <= count[ch_idx] + incr[ch_idx]. When ch_idx==NUM_CH-1, go to IDLE and assert done the next cycle. Otherwise ch_idx++.
- Timing: an enable pulse seen in IDLE at cycle t updates channel 0 at edge t+1+SETTLE_CYC+1 and channel k at one cycle later per index.
  - With NUM_CH=1 and SETTLE_CYC=1 this matches the legacy 3-cycle IDLE/wait/accumulate cadence.
- Enable changes outside IDLE are ignored; the mask is frozen for the whole pass.
- Arithmetic: addition is modulo 2^CNT_W, i.e. silent wrap (see optional feature).
- Increment writes:
  - wr_en writes incr[wr_ch] at any state.
  - A write colliding with an ACC of the same channel in the same cycle: the accumulation uses the old increment, and the new value applies from the next pass.
  - wr_ch >= NUM_CH: the write is ignored.
- clr:
  - Sets all count to 0 and aborts any pass (state=IDLE, ch_idx=0, no done).
  - Has priority over accumulation and over enable in the same cycle.
  - Increment registers are untouched.
- Reset mid-pass: immediate return to reset values; no done pulse.

Optional Feature:
BLINK_SAT_EN
- Defined:
  - Additions saturate at 2^CNT_W-1 instead of wrapping.
  - Adds output sat, NUM_CH bits, a sticky per-channel flag set when a saturation occurs.
  - sat is cleared by clr or reset.
- Undefined: wrap-around arithmetic; no sat port.

Decomposition:
- Package blink_pkg holds:
  - state enum type (IDLE/SETTLE/ACC, 2-bit encoding);
  - localparam function for channel-index width (clog2, minimum 1).
- One sub-module, blink_acc_unit: the shared adder.
  - Inputs: operand, increment.
  - Outputs: next value, plus overflow / saturated result under BLINK_SAT_EN.
  - Purely combinational; all state stays in blink_multi.

Test Plan:
- Reset then idle: hold RST_N low 3 cycles, release with enable=0 for 20 cycles -> led=0, busy=0, done never pulses.
- Single channel pass: set incr[2]=0x10000 via write, pulse enable=4'b0100 for 1 cycle -> busy for 1+NUM_CH cycles, count[2]=0x10000, led ch2=0x01, other channels 0, done one cycle.
- All channels, repeated: incr[i]=(i+1)<<16, hold enable=4'hF for 10 passes -> led ch i = 10*(i+1), done pulses exactly 10 times.
- Wrap: CNT_W=32, incr[0]=0xFFFF0000, 2 passes -> count[0]=0xFFFE0000. With BLINK_SAT_EN: count[0]=0xFFFFFFFF and sat[0]=1.
- Collision and masking: write incr[1]=0x20000 in the same cycle ch1 accumulates with old incr 0x10000 -> +0x10000 this pass, +0x20000 next. Toggling enable mid-pass does not change the mask.
- Abort: assert clr during ACC at ch_idx=1 -> all count 0 next cycle, state IDLE, no done. Async RST_N drop mid-SETTLE -> outputs 0 immediately, before any clock edge.
